// File: rtl/riscv_sw_debounce.sv
// Per-bit switch debouncer: 2-flop sync, shared sample prescaler,
// per-bit stability counters, sticky change flags and update strobe.
`timescale 1ns/1ps
module riscv_sw_debounce #(
    parameter int W            = 24,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_raw,
    input  logic [W-1:0] clr_changed,
    output logic [W-1:0] sw_clean,
    output logic [W-1:0] sw_changed,
    output logic         sw_change_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

    logic [W-1:0]  sync1_q;
    logic [W-1:0]  sync2_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];
    logic [W-1:0]  clean_q;
    logic [W-1:0]  clean_d;
    logic [W-1:0]  changed_q;
    logic [W-1:0]  changed_d;
    logic          pulse_q;
    logic          pulse_d;
    logic [W-1:0]  flip;

    // Two-flop synchronizer: the only consumer of the raw pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Sample prescaler; tick is high in the last cycle of each period.
    always_comb begin
        tick    = (presc_q == PMAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Per-bit qualification: any agreement with the clean value restarts it.
    always_comb begin
        clean_d = clean_q;
        flip    = '0;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CMAX) begin
                    cnt_d[i]   = '0;
                    clean_d[i] = sync2_q[i];
                    flip[i]    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        changed_d = (changed_q & ~clr_changed) | flip;
        pulse_d   = |flip;
    end

    // State registers for prescaler, counters, clean value and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            clean_q   <= '0;
            changed_q <= '0;
            pulse_q   <= 1'b0;
            for (int i = 0; i < W; i++) cnt_q[i] <= '0;
        end else begin
            presc_q   <= presc_d;
            clean_q   <= clean_d;
            changed_q <= changed_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign sw_clean        = clean_q;
    assign sw_changed      = changed_q;
    assign sw_change_pulse = pulse_q;

endmodule
